// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, EX/MEM control payload and EX/MEM FSM states.
package pipe_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 3;

  // Memory/writeback control carried from EX into MEM.
  typedef struct packed {
    logic             valid;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             halt;
    logic             err;
    logic [REG_W-1:0] write_reg;
  } exmem_ctrl_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } exmem_state_t;

endpackage

// File: rtl/store_fwd_mux.sv
// WB-to-store-data forward: picks the writeback result when it targets the
// register a store is about to write to memory.
// Ports: wb_reg_write/wb_write_reg/wb_data (writeback result), rt_reg (store
// source register), is_store, store_data (value read in EX), fwd_data_c (selected data).
module store_fwd_mux
  import pipe_pkg::*;
(
  input  logic              wb_reg_write,
  input  logic [REG_W-1:0]  wb_write_reg,
  input  logic [REG_W-1:0]  rt_reg,
  input  logic              is_store,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] fwd_data_c
);

  always_comb begin
    fwd_data_c = store_data;
    if (wb_reg_write && (wb_write_reg == rt_reg) && is_store) begin
      fwd_data_c = wb_data;
    end
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with store-data forward, misalignment trapping and
// a sticky halt state that freezes the pipeline tail until reset.
// Ports: clk, rst (sync, active high), stall, flush, ex_* (execute-stage
// payload), wb_* (writeback result for forwarding), mem_*/alu_data/mem_data2/
// isHalt/err (registered MEM-stage payload), halted (sticky halt indicator).
module ex_mem_reg
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_data,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rt_reg,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic [REG_W-1:0]  ex_write_reg,
  input  logic              ex_mem_to_reg,
  input  logic              ex_halt,
  input  logic              ex_err,
  input  logic              wb_reg_write,
  input  logic [REG_W-1:0]  wb_write_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              mem_valid,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_reg_write,
  output logic              mem_mem_to_reg,
  output logic [DATA_W-1:0] alu_data,
  output logic [DATA_W-1:0] mem_data2,
  output logic [REG_W-1:0]  mem_write_reg,
  output logic              isHalt,
  output logic              err,
  output logic              halted
);

  exmem_state_t      state_q, state_d;
  exmem_ctrl_t       ctrl_q, ctrl_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic              halted_q, halted_d;
  logic [DATA_W-1:0] fwd_data_c;
  logic              load_c;
  logic              misalign_c;
  logic              err_c;

  store_fwd_mux u_store_fwd_mux (
    .wb_reg_write (wb_reg_write),
    .wb_write_reg (wb_write_reg),
    .rt_reg       (ex_rt_reg),
    .is_store     (ex_mem_write),
    .wb_data      (wb_data),
    .store_data   (ex_store_data),
    .fwd_data_c   (fwd_data_c)
  );

  // Capture qualifiers: a real instruction arriving while running and not held/flushed.
  always_comb begin
    load_c     = (state_q == RUN) && !stall && !flush && ex_valid;
    misalign_c = (ex_mem_read | ex_mem_write) & ex_alu_data[0];
    err_c      = ex_err | misalign_c;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a captured halt or error parks the FSM until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (load_c && (ex_halt || err_c)) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Next output-register values.
  always_comb begin
    ctrl_d   = ctrl_q;
    alu_d    = alu_q;
    data2_d  = data2_q;
    halted_d = (state_d == HALTED);
    case (state_q)
      RUN: begin
        if (!stall) begin
          if (load_c) begin
            ctrl_d.valid      = 1'b1;
            ctrl_d.mem_read   = ex_mem_read & ~misalign_c;
            ctrl_d.mem_write  = ex_mem_write & ~misalign_c;
            ctrl_d.reg_write  = ex_reg_write;
            ctrl_d.mem_to_reg = ex_mem_to_reg;
            ctrl_d.halt       = ex_halt;
            ctrl_d.err        = err_c;
            ctrl_d.write_reg  = ex_write_reg;
            alu_d             = ex_alu_data;
            data2_d           = fwd_data_c;
          end else begin
            ctrl_d  = '0;
            alu_d   = '0;
            data2_d = '0;
          end
        end
      end
      // Frozen, but the memory access is only presented for one cycle.
      HALTED: begin
        ctrl_d.mem_read  = 1'b0;
        ctrl_d.mem_write = 1'b0;
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      alu_q    <= '0;
      data2_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      alu_q    <= alu_d;
      data2_q  <= data2_d;
      halted_q <= halted_d;
    end
  end

  assign mem_valid      = ctrl_q.valid;
  assign mem_read       = ctrl_q.mem_read;
  assign mem_write      = ctrl_q.mem_write;
  assign mem_reg_write  = ctrl_q.reg_write;
  assign mem_mem_to_reg = ctrl_q.mem_to_reg;
  assign mem_write_reg  = ctrl_q.write_reg;
  assign isHalt         = ctrl_q.halt;
  assign err            = ctrl_q.err;
  assign alu_data       = alu_q;
  assign mem_data2      = data2_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed literal checks plus randomized traffic checked
// every cycle against a behavioural model of the EX/MEM register.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid;
  logic [15:0] ex_alu_data, ex_store_data, wb_data;
  logic [2:0]  ex_rt_reg, ex_write_reg, wb_write_reg;
  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic        ex_halt, ex_err, wb_reg_write;

  logic        mem_valid, mem_read, mem_write, mem_reg_write, mem_mem_to_reg;
  logic [15:0] alu_data, mem_data2;
  logic [2:0]  mem_write_reg;
  logic        isHalt, err, halted;

  // Model of the visible outputs.
  logic        m_valid, m_rd, m_wr, m_rw, m_m2r, m_halt, m_err, m_halted;
  logic [15:0] m_alu, m_d2;
  logic [2:0]  m_wreg;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_data(ex_alu_data), .ex_store_data(ex_store_data), .ex_rt_reg(ex_rt_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_write_reg(ex_write_reg), .ex_mem_to_reg(ex_mem_to_reg), .ex_halt(ex_halt),
    .ex_err(ex_err), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_data(wb_data), .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg), .alu_data(alu_data),
    .mem_data2(mem_data2), .mem_write_reg(mem_write_reg), .isHalt(isHalt), .err(err),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural rule set applied to the inputs seen at an edge.
  task automatic model_update();
    logic misal, e;
    if (rst) begin
      {m_valid, m_rd, m_wr, m_rw, m_m2r, m_halt, m_err, m_halted} = '0;
      m_alu = '0; m_d2 = '0; m_wreg = '0;
    end else if (m_halted) begin
      m_rd = 1'b0;
      m_wr = 1'b0;
    end else if (stall) begin
      // hold
    end else if (flush || !ex_valid) begin
      {m_valid, m_rd, m_wr, m_rw, m_m2r, m_halt, m_err} = '0;
      m_alu = '0; m_d2 = '0; m_wreg = '0;
    end else begin
      misal    = (ex_mem_read || ex_mem_write) && (ex_alu_data % 2 == 1);
      e        = ex_err || misal;
      m_valid  = 1'b1;
      m_rd     = ex_mem_read && !misal;
      m_wr     = ex_mem_write && !misal;
      m_rw     = ex_reg_write;
      m_m2r    = ex_mem_to_reg;
      m_halt   = ex_halt;
      m_err    = e;
      m_wreg   = ex_write_reg;
      m_alu    = ex_alu_data;
      m_d2     = (ex_mem_write && wb_reg_write && wb_write_reg == ex_rt_reg) ? wb_data : ex_store_data;
      m_halted = ex_halt || e;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_in();
    rst = 0; stall = 0; flush = 0; ex_valid = 0;
    ex_alu_data = '0; ex_store_data = '0; ex_rt_reg = '0; ex_write_reg = '0;
    ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0; ex_mem_to_reg = 0;
    ex_halt = 0; ex_err = 0; wb_reg_write = 0; wb_write_reg = '0; wb_data = '0;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_valid", 16'(mem_valid), 16'(m_valid));
      chk("mem_read", 16'(mem_read), 16'(m_rd));
      chk("mem_write", 16'(mem_write), 16'(m_wr));
      chk("mem_reg_write", 16'(mem_reg_write), 16'(m_rw));
      chk("mem_mem_to_reg", 16'(mem_mem_to_reg), 16'(m_m2r));
      chk("alu_data", alu_data, m_alu);
      chk("mem_data2", mem_data2, m_d2);
      chk("mem_write_reg", 16'(mem_write_reg), 16'(m_wreg));
      chk("isHalt", 16'(isHalt), 16'(m_halt));
      chk("err", 16'(err), 16'(m_err));
      chk("halted", 16'(halted), 16'(m_halted));
    end
  end

  initial begin
    logic [31:0] r;
    clear_in();
    rst = 1;
    step();
    step();
    rst = 0;
    chk_en = 1'b1;
    chk("reset_alu", alu_data, 16'h0000);
    chk("reset_valid", 16'(mem_valid), 16'h0);
    chk("reset_halted", 16'(halted), 16'h0);

    // Load/propagate
    ex_valid = 1; ex_alu_data = 16'h0040; ex_mem_read = 1; ex_write_reg = 3'd5;
    ex_reg_write = 1; ex_mem_to_reg = 1;
    step();
    chk("load_alu", alu_data, 16'h0040);
    chk("load_rd", 16'(mem_read), 16'h1);
    chk("load_wreg", 16'(mem_write_reg), 16'h5);
    chk("load_err", 16'(err), 16'h0);

    // Stall three cycles with changing EX inputs
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      ex_alu_data = 16'(16'h0100 + 16'(i * 2)); ex_write_reg = 3'(i);
      step();
      chk("stall_alu", alu_data, 16'h0040);
      chk("stall_wreg", 16'(mem_write_reg), 16'h5);
    end

    // Flush with a valid store
    stall = 0; flush = 1; ex_mem_read = 0; ex_mem_write = 1; ex_alu_data = 16'h0020;
    step();
    chk("flush_wr", 16'(mem_write), 16'h0);
    chk("flush_valid", 16'(mem_valid), 16'h0);
    chk("flush_rw", 16'(mem_reg_write), 16'h0);

    // Stall and flush together hold
    flush = 0; ex_alu_data = 16'h0022; ex_write_reg = 3'd3;
    step();
    stall = 1; flush = 1; ex_alu_data = 16'h0066;
    step();
    chk("stallflush_alu", alu_data, 16'h0022);
    chk("stallflush_wr", 16'(mem_write), 16'h1);

    // Forwarding hit and miss
    stall = 0; flush = 0; ex_mem_write = 1; ex_alu_data = 16'h0010;
    ex_rt_reg = 3'd2; ex_store_data = 16'h1111;
    wb_reg_write = 1; wb_write_reg = 3'd2; wb_data = 16'hBEEF;
    step();
    chk("fwd_hit", mem_data2, 16'hBEEF);
    wb_write_reg = 3'd3;
    step();
    chk("fwd_miss", mem_data2, 16'h1111);

    // Misaligned store traps and halts
    ex_alu_data = 16'h0013;
    step();
    chk("misal_wr", 16'(mem_write), 16'h0);
    chk("misal_err", 16'(err), 16'h1);
    chk("misal_halted", 16'(halted), 16'h1);
    ex_alu_data = 16'h0200; flush = 1;
    step();
    flush = 0; stall = 1;
    step();
    stall = 0;
    step();
    chk("misal_frozen_alu", alu_data, 16'h0013);
    chk("misal_frozen_err", 16'(err), 16'h1);

    // Reset leaves halt
    rst = 1;
    step();
    rst = 0;
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_alu", alu_data, 16'h0000);

    // Halting store: write presented once, isHalt sticky
    ex_alu_data = 16'h0100; ex_mem_write = 1; ex_halt = 1; ex_store_data = 16'h5A5A;
    wb_reg_write = 0;
    step();
    chk("halt_wr1", 16'(mem_write), 16'h1);
    chk("halt_ishalt1", 16'(isHalt), 16'h1);
    chk("halt_halted", 16'(halted), 16'h1);
    ex_halt = 0; ex_alu_data = 16'h0300;
    step();
    chk("halt_wr2", 16'(mem_write), 16'h0);
    chk("halt_ishalt2", 16'(isHalt), 16'h1);
    chk("halt_alu", alu_data, 16'h0100);
    flush = 1; stall = 1;
    step();
    chk("halt_sf_alu", alu_data, 16'h0100);
    chk("halt_sf_d2", mem_data2, 16'h5A5A);

    // Reset then resume capture
    flush = 0; stall = 0; rst = 1;
    step();
    rst = 0; ex_mem_write = 0; ex_mem_read = 1; ex_alu_data = 16'h0040;
    step();
    chk("resume_alu", alu_data, 16'h0040);
    chk("resume_halted", 16'(halted), 16'h0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r = $urandom;
      rst      = (r[6:0] % 100) < 4;
      stall    = ($urandom_range(0, 99) < 20);
      flush    = ($urandom_range(0, 99) < 15);
      ex_valid = ($urandom_range(0, 99) < 85);
      r = $urandom;
      ex_alu_data = r[15:0];
      if ($urandom_range(0, 99) < 92) ex_alu_data[0] = 1'b0;
      ex_store_data = r[31:16];
      r = $urandom;
      ex_rt_reg     = r[2:0];
      ex_write_reg  = r[5:3];
      wb_write_reg  = r[8:6];
      wb_reg_write  = r[9];
      ex_reg_write  = r[10];
      ex_mem_to_reg = r[11];
      ex_mem_read   = (r[13:12] == 2'd1);
      ex_mem_write  = (r[13:12] == 2'd2);
      wb_data       = r[31:16];
      ex_halt = ($urandom_range(0, 99) < 3);
      ex_err  = ($urandom_range(0, 99) < 2);
      step();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
